// File: rtl/mig_write_arbiter_if.sv
// Bundle of every stream signal around the MIG write arbiter.
//   s0_* / s1_* : 128-bit chunk streams from the left (0) and right (1) stackers
//   m_*         : registered beat towards the DDR traffic generator,
//                 carrying data, word address, source id and tlast
//   frame_err   : sticky per-source "offset wrapped without tlast" flags
// Modports:
//   slave  - the arbiter itself (sink of s0/s1, source of m_* and frame_err)
//   master - the surrounding logic (drives s0/s1, sinks m_*)
interface mig_write_arbiter_if #(
  parameter int ADDR_WIDTH = 27
);
  logic                  s0_tvalid;
  logic                  s0_tready;
  logic [127:0]          s0_tdata;
  logic                  s0_tlast;
  logic                  s1_tvalid;
  logic                  s1_tready;
  logic [127:0]          s1_tdata;
  logic                  s1_tlast;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [127:0]          m_tdata;
  logic [ADDR_WIDTH-1:0] m_taddr;
  logic                  m_tid;
  logic                  m_tlast;
  logic [1:0]            frame_err;

  modport slave (
    input  s0_tvalid, s0_tdata, s0_tlast,
    input  s1_tvalid, s1_tdata, s1_tlast,
    input  m_tready,
    output s0_tready, s1_tready,
    output m_tvalid, m_tdata, m_taddr, m_tid, m_tlast,
    output frame_err
  );

  modport master (
    output s0_tvalid, s0_tdata, s0_tlast,
    output s1_tvalid, s1_tdata, s1_tlast,
    output m_tready,
    input  s0_tready, s1_tready,
    input  m_tvalid, m_tdata, m_taddr, m_tid, m_tlast,
    input  frame_err
  );
endinterface

// File: rtl/mig_write_arbiter.sv
// Round-robin arbiter sharing the single MIG write-data path between the two
// camera stacker streams. Each grant carries up to BURST_LEN chunks, ends early
// on tlast, or is released after TIMEOUT idle cycles. Every accepted chunk gets
// a frame-buffer word address BASEi + offset_i; offsets persist across grants.
// Ports:
//   clk_in - system clock
//   rst_in - synchronous reset, active high
//   bus    - mig_write_arbiter_if.slave (s0/s1 inputs, m_* output, frame_err)
module mig_write_arbiter #(
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 4800,
  parameter int ADDR_WIDTH  = 27,
  parameter int BASE0       = 0,
  parameter int BASE1       = 4800,
  parameter int TIMEOUT     = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  mig_write_arbiter_if.slave   bus
);

  localparam int OFF_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [OFF_W-1:0]  OFF_MAX  = OFF_W'(FRAME_WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                state, state_nx;
  logic                  last;            // 1 = source 1 held the most recent grant
  logic [BEAT_W-1:0]     beat;
  logic [IDLE_W-1:0]     idle;
  logic [OFF_W-1:0]      off0, off1;
  logic                  m_valid_q;
  logic [127:0]          m_data_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic                  m_id_q;
  logic                  m_last_q;
  logic [1:0]            err_q;
  logic                  out_free, ready0, ready1, acc0, acc1;

  always_comb begin
    out_free = !m_valid_q || bus.m_tready;
    ready0   = (state == GRANT0) && out_free;
    ready1   = (state == GRANT1) && out_free;
    acc0     = ready0 && bus.s0_tvalid;
    acc1     = ready1 && bus.s1_tvalid;
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.s0_tvalid && bus.s1_tvalid) state_nx = last ? GRANT0 : GRANT1;
        else if (bus.s0_tvalid)             state_nx = GRANT0;
        else if (bus.s1_tvalid)             state_nx = GRANT1;
      end
      GRANT0: begin
        if (acc0) begin
          if (beat == BEAT_MAX || bus.s0_tlast) state_nx = IDLE;
        end else if (!bus.s0_tvalid && idle == IDLE_MAX) begin
          state_nx = IDLE;
        end
      end
      GRANT1: begin
        if (acc1) begin
          if (beat == BEAT_MAX || bus.s1_tlast) state_nx = IDLE;
        end else if (!bus.s1_tvalid && idle == IDLE_MAX) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      last      <= 1'b1;
      beat      <= '0;
      idle      <= '0;
      off0      <= '0;
      off1      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_addr_q  <= '0;
      m_id_q    <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state <= state_nx;

      // Grant entry resets per-burst counters; blocked-but-valid cycles are not idle.
      if (state == IDLE && state_nx != IDLE) begin
        last <= (state_nx == GRANT1);
        beat <= '0;
        idle <= '0;
      end else if (acc0 || acc1) begin
        beat <= beat + 1'b1;
        idle <= '0;
      end else if ((state == GRANT0 && !bus.s0_tvalid) ||
                   (state == GRANT1 && !bus.s1_tvalid)) begin
        idle <= idle + 1'b1;
      end

      if (acc0) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.s0_tdata;
        m_last_q  <= bus.s0_tlast;
        m_id_q    <= 1'b0;
        m_addr_q  <= ADDR_WIDTH'(BASE0) + ADDR_WIDTH'(off0);
      end else if (acc1) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.s1_tdata;
        m_last_q  <= bus.s1_tlast;
        m_id_q    <= 1'b1;
        m_addr_q  <= ADDR_WIDTH'(BASE1) + ADDR_WIDTH'(off1);
      end else if (bus.m_tready) begin
        m_valid_q <= 1'b0;
      end

      if (acc0) begin
        if (bus.s0_tlast) off0 <= '0;
        else if (off0 == OFF_MAX) begin
          off0     <= '0;
          err_q[0] <= 1'b1;
        end else off0 <= off0 + 1'b1;
      end

      if (acc1) begin
        if (bus.s1_tlast) off1 <= '0;
        else if (off1 == OFF_MAX) begin
          off1     <= '0;
          err_q[1] <= 1'b1;
        end else off1 <= off1 + 1'b1;
      end
    end
  end

  assign bus.s0_tready = ready0;
  assign bus.s1_tready = ready1;
  assign bus.m_tvalid  = m_valid_q;
  assign bus.m_tdata   = m_data_q;
  assign bus.m_taddr   = m_addr_q;
  assign bus.m_tid     = m_id_q;
  assign bus.m_tlast   = m_last_q;
  assign bus.frame_err = err_q;

endmodule

// File: doc/mig_write_arbiter.md
Name: mig_write_arbiter

Overview:
- Shares the single MIG write-data path between two 128-bit chunk streams, one from each camera's stacker (left = source 0, right = source 1).
- Grants bursts round-robin and generates a per-source frame-buffer word address for every chunk.
- Forwards data, address and source id through one registered output stage to the DDR traffic generator.

Parameters:
- BURST_LEN, 16, maximum chunks per grant.
- FRAME_WORDS, 4800, 128-bit words per frame per source.
- ADDR_WIDTH, 27, width of the word address.
- BASE0, 0, frame-buffer base word address for source 0.
- BASE1, 4800, frame-buffer base word address for source 1.
- TIMEOUT, 64, idle cycles with no valid on the granted source before the grant is released.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active high.
- s0_tvalid  input  1  source 0 chunk valid.
- s0_tready  output  1  source 0 chunk ready.
- s0_tdata  input  128  source 0 chunk.
- s0_tlast  input  1  source 0 end of frame.
- s1_tvalid  input  1  source 1 chunk valid.
- s1_tready  output  1  source 1 chunk ready.
- s1_tdata  input  128  source 1 chunk.
- s1_tlast  input  1  source 1 end of frame.
- m_tvalid  output  1  output beat valid.
- m_tready  input  1  downstream ready.
- m_tdata  output  128  forwarded chunk.
- m_taddr  output  ADDR_WIDTH  word address (BASEi + offset).
- m_tid  output  1  source index of the beat.
- m_tlast  output  1  forwarded tlast.
- frame_err  output  2  sticky per source: offset wrapped without tlast.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk_in.
  - rst_in is synchronous, active high.
  - Reset values: m_tvalid=0, m_tdata=0, m_taddr=0, m_tid=0, m_tlast=0, frame_err=0.
  - Reset also clears both offsets, the beat counter and the idle counter, sets the round-robin pointer to last=1 (so source 0 wins first), and puts the FSM in IDLE.
  - Reset mid-burst abandons the burst; no partial state survives.
- Handshake:
  - Input accept_i = si_tvalid && si_tready.
  - si_tready = (state==GRANTi) && (!m_tvalid || m_tready); it is 0 for the non-granted source and in IDLE.
  - Output stage is a single register. On accept_i, load m_tdata, m_tlast, m_tid=i and m_taddr=BASEi+offset_i, and set m_tvalid=1.
  - Otherwise, if m_tready, clear m_tvalid.
  - Latency from input accept to m_tvalid is 1 cycle.
  - Outputs are held stable while m_tvalid && !m_tready.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE, only one source valid: go to that source's GRANT state.
  - IDLE, both sources valid: go to GRANT for the source not equal to last.
  - IDLE, none valid: stay.
  - Entering a grant updates last, zeroes the beat counter and zeroes the idle counter.
  - Arbitration costs one bubble cycle per grant.
  - GRANTi, on accept: beat counter increments and the idle counter clears.
  - GRANTi leaves to IDLE on the same cycle as an accepted beat when beat==BURST_LEN-1 or si_tlast=1.
  - GRANTi, si_tvalid=0: idle counter increments. At idle==TIMEOUT-1 the FSM goes to IDLE and the burst is truncated.
  - Cycles where si_tvalid=1 but output backpressure blocks the accept do not count as idle.
- Addressing:
  - offset_i is ceil(log2(FRAME_WORDS)) bits, counting 128-bit words.
  - On accept_i with tlast=1, offset_i <= 0.
  - Else on accept_i with offset_i==FRAME_WORDS-1, offset_i <= 0 and frame_err[i] <= 1. frame_err is sticky until reset.
  - Else on accept_i, offset_i increments by 1.
  - m_taddr is computed modulo 2^ADDR_WIDTH.
- Offsets persist across grants: a frame is split over many bursts interleaved with the other source.
- Data from one source is never reordered. Beats from different sources interleave only at burst boundaries.

Test Plan:
- Source 0 only, 20 chunks, no tlast, m_tready=1:
  - beats 0-15 get addr 0..15 with tid=0;
  - IDLE bubble;
  - beats 16-19 get addr 16..19.
- Both sources continuously valid:
  - grants alternate 0,1,0,1 with 16 beats each;
  - source 1 addresses start at 4800 and continue 4816... on its second grant.
- Source 0 tlast on beat 5:
  - burst ends after beat 5 (addr 5);
  - source 0's next chunk gets addr 0 (BASE0).
- Source 1 granted, then s1_tvalid dropped after 3 beats while s0 is valid:
  - grant releases after 64 idle cycles;
  - source 0 is granted next.
- m_tready=0 for 10 cycles mid-burst:
  - m_* held stable, si_tready=0, no idle timeout;
  - no beats lost or duplicated after release.
- Source 0 sends 4801 chunks without tlast:
  - chunk 4801 gets addr 0 and frame_err[0]=1.
  - rst_in mid-burst clears frame_err, offsets and m_tvalid; the next grant goes to source 0.
